// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues registered reads to instruction memory, holds
// each fetched word for decode until it is accepted, and supports redirect and halt.
module instruction_fetch #(
   parameter int                           ADDRESS_BUS_WIDTH = 10,
   parameter int                           INSTRUCTION_WIDTH = 19,
   parameter logic [ADDRESS_BUS_WIDTH-1:0] RESET_PC          = 10'h200,
   parameter logic [4:0]                   HALT_OPCODE       = 5'b11111
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [ADDRESS_BUS_WIDTH-1:0] imem_addr,
   output logic                         imem_read,
   output logic                         imem_write,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
   output logic [INSTRUCTION_WIDTH-1:0] instr_out,
   output logic [ADDRESS_BUS_WIDTH-1:0] instr_pc,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   input  logic                         redirect_valid,
   input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_addr,
   output logic                         halted,
   output logic [15:0]                  fetch_count
);

   typedef enum logic [1:0] {
      S_ISSUE   = 2'b00,
      S_CAPTURE = 2'b01,
      S_HOLD    = 2'b10,
      S_HALT    = 2'b11
   } state_t;

   localparam logic [ADDRESS_BUS_WIDTH-1:0] PC_STEP = ADDRESS_BUS_WIDTH'(4);

   state_t                         r_state;
   logic [ADDRESS_BUS_WIDTH-1:0]   r_pc;
   logic [INSTRUCTION_WIDTH-1:0]   r_instr_out;
   logic [ADDRESS_BUS_WIDTH-1:0]   r_instr_pc;
   logic                           r_instr_valid;
   logic                           r_halted;
   logic [15:0]                    r_fetch_count;

   state_t                         w_next_state;
   logic [ADDRESS_BUS_WIDTH-1:0]   w_next_pc;
   logic [INSTRUCTION_WIDTH-1:0]   w_next_instr_out;
   logic [ADDRESS_BUS_WIDTH-1:0]   w_next_instr_pc;
   logic                           w_next_instr_valid;
   logic                           w_next_halted;
   logic [15:0]                    w_next_fetch_count;
   logic                           w_handshake;
   logic [ADDRESS_BUS_WIDTH-1:0]   w_redirect_pc;
   logic                           w_unused_addr_bits;

   // The PC is word aligned, so the byte-offset bits of a redirect target are dropped.
   assign w_redirect_pc      = {redirect_addr[ADDRESS_BUS_WIDTH-1:2], 2'b00};
   assign w_unused_addr_bits = ^redirect_addr[1:0];

   // Gating with rst_n keeps the read strobe quiet while reset is held even though
   // the state register already sits in S_ISSUE.
   assign imem_read   = (r_state == S_ISSUE) & rst_n;
   assign imem_addr   = r_pc;
   assign imem_write  = 1'b0;
   assign instr_out   = r_instr_out;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_instr_valid;
   assign halted      = r_halted;
   assign fetch_count = r_fetch_count;

   // Next-state and next-datapath computation.
   always_comb begin
      w_next_state       = r_state;
      w_next_pc          = r_pc;
      w_next_instr_out   = r_instr_out;
      w_next_instr_pc    = r_instr_pc;
      w_next_instr_valid = r_instr_valid;
      w_next_halted      = r_halted;
      w_handshake        = (r_state == S_HOLD) & r_instr_valid & instr_ready;

      if (w_handshake) begin
         w_next_fetch_count = r_fetch_count + 16'd1;
      end else begin
         w_next_fetch_count = r_fetch_count;
      end

      case (r_state)
         S_ISSUE: begin
            w_next_state = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_next_instr_out   = imem_data;
            w_next_instr_pc    = r_pc;
            w_next_instr_valid = 1'b1;
            w_next_state       = S_HOLD;
         end
         S_HOLD: begin
            if (w_handshake) begin
               w_next_pc          = r_pc + PC_STEP;
               w_next_instr_valid = 1'b0;
               if (r_instr_out[INSTRUCTION_WIDTH-1 -: 5] == HALT_OPCODE) begin
                  w_next_state  = S_HALT;
                  w_next_halted = 1'b1;
               end else begin
                  w_next_state  = S_ISSUE;
               end
            end else begin
               w_next_state = S_HOLD;
            end
         end
         S_HALT: begin
            w_next_state = S_HALT;
         end
         default: begin
            w_next_state       = S_ISSUE;
            w_next_instr_valid = 1'b0;
         end
      endcase

      // Redirect overrides everything; in-flight capture data is dropped, but a
      // coincident handshake is still counted above.
      if (redirect_valid) begin
         w_next_state       = S_ISSUE;
         w_next_pc          = w_redirect_pc;
         w_next_instr_out   = r_instr_out;
         w_next_instr_pc    = r_instr_pc;
         w_next_instr_valid = 1'b0;
         w_next_halted      = 1'b0;
      end else begin
         w_next_halted      = w_next_halted;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_ISSUE;
         r_pc          <= RESET_PC;
         r_instr_out   <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_fetch_count <= 16'd0;
      end else begin
         r_state       <= w_next_state;
         r_pc          <= w_next_pc;
         r_instr_out   <= w_next_instr_out;
         r_instr_pc    <= w_next_instr_pc;
         r_instr_valid <= w_next_instr_valid;
         r_halted      <= w_next_halted;
         r_fetch_count <= w_next_fetch_count;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized bench for instruction_fetch, checked against a
// transaction-level latency model (issue, valid two cycles later, hold until accepted).
module tb_instruction_fetch;
   localparam int AW = 10;
   localparam int IW = 19;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] imem_addr;
   logic          imem_read;
   logic          imem_write;
   logic [IW-1:0] imem_data;
   logic [IW-1:0] instr_out;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_addr = '0;
   logic          halted;
   logic [15:0]   fetch_count;

   logic [IW-1:0] mem [256];

   int            checks = 0;
   int            errors = 0;

   // Model: m_due is the number of cycles until the fetched word is presented.
   int            m_due;
   logic [AW-1:0] m_pc;
   logic [15:0]   m_count;
   bit            m_halted;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_read) imem_data <= mem[imem_addr[AW-1:2]];
   end

   instruction_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(imem_addr), .imem_read(imem_read), .imem_write(imem_write),
      .imem_data(imem_data),
      .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .halted(halted), .fetch_count(fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit ev;
      bit er;
      ev = (m_due == 0) && !m_halted;
      er = (m_due == 2) && !m_halted;
      chk("instr_valid", 32'(instr_valid), 32'(ev));
      chk("imem_read", 32'(imem_read), 32'(er));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("fetch_count", 32'(fetch_count), 32'(m_count));
      chk("imem_write", 32'(imem_write), 32'd0);
      if (er) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      if (ev) begin
         chk("instr_out", 32'(instr_out), 32'(mem[m_pc[AW-1:2]]));
         chk("instr_pc", 32'(instr_pc), 32'(m_pc));
      end
   endtask

   task automatic model_edge(input bit rdy, input bit rv, input logic [AW-1:0] ra);
      logic [IW-1:0] word;
      if ((m_due == 0) && !m_halted && rdy) m_count = m_count + 16'd1;
      if (rv) begin
         m_pc     = {ra[AW-1:2], 2'b00};
         m_due    = 2;
         m_halted = 1'b0;
      end else if (m_halted) begin
         m_due = m_due;
      end else if (m_due > 0) begin
         m_due = m_due - 1;
      end else if (rdy) begin
         word = mem[m_pc[AW-1:2]];
         m_pc = m_pc + 10'd4;
         if (word[18:14] == 5'h1F) m_halted = 1'b1;
         else m_due = 2;
      end
   endtask

   task automatic cycle(input bit rdy, input bit rv, input logic [AW-1:0] ra);
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_addr  = ra;
      @(posedge clk);
      model_edge(rdy, rv, ra);
      @(negedge clk);
      redirect_valid = 1'b0;
      check_all();
   endtask

   task automatic run_ready(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0);
   endtask

   task automatic stall_until(input int d);
      for (int i = 0; i < 10 && m_due != d; i++) cycle(1'b0, 1'b0, '0);
   endtask

   // Reset is asserted away from any clock edge so its asynchronous effect is visible.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_read", 32'(imem_read), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_count", 32'(fetch_count), 32'd0);
      chk("rst_instr_out", 32'(instr_out), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      m_pc     = 10'h200;
      m_due    = 2;
      m_count  = 16'd0;
      m_halted = 1'b0;
      #1;
      check_all();
   endtask

   initial begin
      logic [IW-1:0] w;
      for (int i = 0; i < 256; i++) begin
         w = IW'($urandom);
         if (w[18:14] == 5'h1F) w[18] = 1'b0;
         mem[i] = w;
      end
      mem[8'h80] = 19'h20110;
      mem[8'h81] = 19'h20220;
      mem[8'h82] = 19'h07600;
      mem[8'h83] = 19'h24330;
      mem[8'hC0] = 19'h7C000;
      mem[8'hFF] = 19'h07600;

      #2;
      do_reset();
      // Back-to-back program fetch with decode always ready.
      run_ready(12);
      // Decode stalls for five cycles while a word is held.
      stall_until(0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);
      run_ready(4);
      // Redirect during capture discards the in-flight word.
      stall_until(1);
      cycle(1'b1, 1'b1, 10'h213);
      run_ready(6);
      // PC wrap from the top word to zero.
      cycle(1'b1, 1'b1, 10'h3FC);
      run_ready(7);
      // Halt instruction, then resume by redirect.
      cycle(1'b1, 1'b1, 10'h300);
      run_ready(10);
      cycle(1'b1, 1'b1, 10'h200);
      run_ready(6);
      // Redirect coinciding with a handshake.
      stall_until(0);
      cycle(1'b1, 1'b1, 10'h240);
      run_ready(6);
      // Asynchronous reset while a word is held.
      stall_until(0);
      #2;
      do_reset();
      run_ready(6);
      // Randomized decode backpressure and redirects.
      for (int i = 0; i < 500; i++) begin
         cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), AW'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
